// File: rtl/bh1750_ctrl.sv
// bh1750_ctrl: drives the I2C master to power up the BH1750, put it in
// continuous high-resolution mode and then read it periodically. Each raw
// count is converted to lux (binary and 5-digit BCD) and handed to the LCD
// formatter with a one-cycle valid strobe. A stalled transaction is recovered
// by holding the I2C master in reset and re-running the init sequence.
module bh1750_ctrl #(
   parameter int          P_BOOT_CYCLES    = 500_000,
   parameter int          P_MEAS_CYCLES    = 9_000_000,
   parameter int          P_TIMEOUT_CYCLES = 1_000_000,
   parameter logic [7:0]  P_OP_PWR_ON      = 8'h01,
   parameter logic [7:0]  P_OP_MODE        = 8'h10
) (
   input  logic          i_clk,
   input  logic          i_rst,
   output logic          o_i2c_start,
   output logic          o_i2c_rw,
   output logic [7:0]    o_i2c_opcode,
   output logic          o_i2c_rst_n,
   input  logic          i_i2c_busy,
   input  logic          i_i2c_done,
   input  logic [15:0]   i_i2c_data,
   output logic [15:0]   o_lux,
   output logic [19:0]   o_lux_bcd,
   output logic          o_valid,
   output logic          o_error
);

   localparam int MAX_AB  = (P_BOOT_CYCLES > P_MEAS_CYCLES) ? P_BOOT_CYCLES : P_MEAS_CYCLES;
   localparam int MAX_CYC = (MAX_AB > P_TIMEOUT_CYCLES) ? MAX_AB : P_TIMEOUT_CYCLES;
   localparam int CW_RAW  = $clog2(MAX_CYC + 1);
   localparam int CW      = (CW_RAW < 5) ? 5 : CW_RAW;

   localparam logic [CW-1:0] BOOT_LAST    = CW'(P_BOOT_CYCLES - 1);
   localparam logic [CW-1:0] MEAS_LAST    = CW'(P_MEAS_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST     = CW'(P_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] RECOVER_LAST = CW'(15);

   typedef enum logic [3:0] {
      S_BOOT,
      S_SETUP,
      S_REQ,
      S_XFER,
      S_WAIT,
      S_CONV,
      S_BCD,
      S_OUT,
      S_RECOVER
   } state_t;

   typedef enum logic [1:0] {
      CMD_PWR_ON,
      CMD_MODE,
      CMD_READ
   } cmd_t;

   state_t        state;
   cmd_t          cmd;
   logic [CW-1:0] cnt;
   logic [CW-1:0] tmo_cnt;
   logic [15:0]   raw;
   logic [15:0]   lux_reg;
   logic [15:0]   bin_sh;
   logic [19:0]   bcd_sh;
   logic [3:0]    bit_cnt;
   logic [15:0]   lux_calc;
   logic [19:0]   bcd_adj;
   logic [19:0]   bcd_next;

   // Multiply by round-up(2^20 * 5/6) and drop 20 bits: exact floor(raw*5/6) for every 16-bit raw
   always_comb begin
      lux_calc = 16'(({20'd0, raw} * 36'd873814) >> 20);
   end

   // One double-dabble step: add 3 to every digit that is 5 or more, then shift in the next binary bit
   always_comb begin
      bcd_adj = bcd_sh;
      for (int d = 0; d < 5; d++) begin
         if (bcd_sh[4*d +: 4] >= 4'd5) begin
            bcd_adj[4*d +: 4] = bcd_sh[4*d +: 4] + 4'd3;
         end
      end
      bcd_next = 20'({bcd_adj, bin_sh[15]});
   end

   // Sequencer: rw/opcode are loaded on entry to S_SETUP so they are settled a cycle before start rises
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= S_BOOT;
         cmd          <= CMD_PWR_ON;
         cnt          <= '0;
         tmo_cnt      <= '0;
         raw          <= '0;
         lux_reg      <= '0;
         bin_sh       <= '0;
         bcd_sh       <= '0;
         bit_cnt      <= '0;
         o_i2c_start  <= 1'b0;
         o_i2c_rw     <= 1'b0;
         o_i2c_opcode <= 8'h00;
         o_i2c_rst_n  <= 1'b0;
         o_lux        <= '0;
         o_lux_bcd    <= '0;
         o_valid      <= 1'b0;
         o_error      <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            S_BOOT: begin
               o_i2c_rst_n <= 1'b1;
               if (cnt == BOOT_LAST) begin
                  cnt          <= '0;
                  cmd          <= CMD_PWR_ON;
                  o_i2c_rw     <= 1'b0;
                  o_i2c_opcode <= P_OP_PWR_ON;
                  state        <= S_SETUP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_SETUP: begin
               tmo_cnt     <= '0;
               o_i2c_start <= 1'b1;
               state       <= S_REQ;
            end

            S_REQ: begin
               if (i_i2c_busy) begin
                  o_i2c_start <= 1'b0;
                  tmo_cnt     <= '0;
                  state       <= S_XFER;
               end else if (tmo_cnt == TMO_LAST) begin
                  o_i2c_start <= 1'b0;
                  o_i2c_rst_n <= 1'b0;
                  o_error     <= 1'b1;
                  cnt         <= '0;
                  state       <= S_RECOVER;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            S_XFER: begin
               if (i_i2c_done) begin
                  case (cmd)
                     CMD_PWR_ON: begin
                        cmd          <= CMD_MODE;
                        o_i2c_rw     <= 1'b0;
                        o_i2c_opcode <= P_OP_MODE;
                        state        <= S_SETUP;
                     end
                     CMD_MODE: begin
                        cnt   <= '0;
                        state <= S_WAIT;
                     end
                     default: begin
                        raw   <= i_i2c_data;
                        state <= S_CONV;
                     end
                  endcase
               end else if (tmo_cnt == TMO_LAST) begin
                  o_i2c_rst_n <= 1'b0;
                  o_error     <= 1'b1;
                  cnt         <= '0;
                  state       <= S_RECOVER;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            S_WAIT: begin
               if (cnt == MEAS_LAST) begin
                  cnt      <= '0;
                  cmd      <= CMD_READ;
                  o_i2c_rw <= 1'b1;
                  state    <= S_SETUP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_CONV: begin
               lux_reg <= lux_calc;
               bin_sh  <= lux_calc;
               bcd_sh  <= '0;
               bit_cnt <= '0;
               state   <= S_BCD;
            end

            S_BCD: begin
               bcd_sh  <= bcd_next;
               bin_sh  <= {bin_sh[14:0], 1'b0};
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd15) begin
                  state <= S_OUT;
               end
            end

            S_OUT: begin
               o_lux     <= lux_reg;
               o_lux_bcd <= bcd_sh;
               o_valid   <= 1'b1;
               o_error   <= 1'b0;
               cnt       <= '0;
               state     <= S_WAIT;
            end

            S_RECOVER: begin
               o_i2c_start <= 1'b0;
               o_i2c_rst_n <= 1'b0;
               o_error     <= 1'b1;
               if (cnt == RECOVER_LAST) begin
                  cnt         <= '0;
                  o_i2c_rst_n <= 1'b1;
                  state       <= S_BOOT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               state <= S_BOOT;
            end
         endcase
      end
   end

endmodule
